// File: rtl/image_ram_responder.sv
// RAM-side responder for the tinyNPU image-read interface: host-preloaded word store
// serving sequential and addressed NPU reads with one-cycle registered return.
module image_ram_responder #(
    parameter int DATA_SIZE  = 8,
    parameter int WORD_WIDTH = DATA_SIZE * 4,
    parameter int RAM_DEPTH  = 32,
    parameter int RAM_AW     = $clog2(RAM_DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_wr_en,
    input  logic [RAM_AW-1:0]     i_wr_addr,
    input  logic [WORD_WIDTH-1:0] i_wr_data,
    input  logic                  i_rst_ram,
    input  logic                  i_en_ram,
    input  logic                  i_addressing,
    input  logic [31:0]           i_address,
    input  logic                  i_read_term,
    output logic [WORD_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_burst_done,
    output logic                  o_addr_err,
    output logic [15:0]           o_read_count,
    output logic [1:0]            o_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    logic [WORD_WIDTH-1:0] mem_r [RAM_DEPTH];
    state_t                state_r;
    logic [RAM_AW-1:0]     rd_ptr_r;
    logic [WORD_WIDTH-1:0] data_r;
    logic                  valid_r;
    logic                  done_r;
    logic                  err_r;
    logic [15:0]           count_r;

    logic [RAM_AW-1:0]     rd_addr_s;
    logic                  oor_s;
    logic [WORD_WIDTH-1:0] rd_word_s;
    logic [RAM_AW-1:0]     ptr_next_s;
    logic [15:0]           count_inc_s;

    // Host write port; memory is never reset, so contents survive i_reset.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            mem_r[i_wr_addr] <= i_wr_data;
        end
    end

    // Read address selection, range check and next-pointer/count arithmetic.
    always_comb begin
        rd_addr_s   = rd_ptr_r;
        oor_s       = 1'b0;
        rd_word_s   = {WORD_WIDTH{1'b0}};
        ptr_next_s  = rd_ptr_r;
        count_inc_s = count_r;
        if (i_addressing) begin
            // Range check on the full 32-bit address before truncation.
            oor_s     = (i_address >= 32'(RAM_DEPTH));
            rd_addr_s = i_address[RAM_AW-1:0];
        end else begin
            oor_s     = 1'b0;
            rd_addr_s = rd_ptr_r;
        end
        if (oor_s) begin
            rd_word_s = {WORD_WIDTH{1'b0}};
        end else begin
            rd_word_s = mem_r[rd_addr_s];
        end
        if (i_addressing) begin
            ptr_next_s = rd_ptr_r;
        end else if (rd_ptr_r == RAM_AW'(RAM_DEPTH - 1)) begin
            ptr_next_s = {RAM_AW{1'b0}};
        end else begin
            ptr_next_s = rd_ptr_r + {{(RAM_AW-1){1'b0}}, 1'b1};
        end
        if (count_r == 16'hFFFF) begin
            count_inc_s = count_r;
        end else begin
            count_inc_s = count_r + 16'd1;
        end
    end

    // Burst FSM with registered read return, done pulse, error flag and word count.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r  <= ST_IDLE;
            rd_ptr_r <= {RAM_AW{1'b0}};
            data_r   <= {WORD_WIDTH{1'b0}};
            valid_r  <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
            count_r  <= 16'd0;
        end else if (i_rst_ram) begin
            state_r  <= ST_IDLE;
            rd_ptr_r <= {RAM_AW{1'b0}};
            data_r   <= {WORD_WIDTH{1'b0}};
            valid_r  <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
            count_r  <= 16'd0;
        end else begin
            case (state_r)
                ST_IDLE, ST_STREAM: begin
                    if (i_en_ram) begin
                        data_r   <= rd_word_s;
                        valid_r  <= 1'b1;
                        rd_ptr_r <= ptr_next_s;
                        count_r  <= count_inc_s;
                        err_r    <= err_r | oor_s;
                    end else begin
                        data_r  <= {WORD_WIDTH{1'b0}};
                        valid_r <= 1'b0;
                    end
                    if (i_read_term) begin
                        state_r <= ST_DRAIN;
                        done_r  <= 1'b1;
                    end else if (i_en_ram) begin
                        state_r <= ST_STREAM;
                        done_r  <= 1'b0;
                    end else begin
                        done_r  <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    // Requests are ignored here; the final count stays visible for this cycle.
                    state_r  <= ST_IDLE;
                    data_r   <= {WORD_WIDTH{1'b0}};
                    valid_r  <= 1'b0;
                    done_r   <= 1'b0;
                    rd_ptr_r <= {RAM_AW{1'b0}};
                    count_r  <= 16'd0;
                end
                default: begin
                    state_r  <= ST_IDLE;
                    data_r   <= {WORD_WIDTH{1'b0}};
                    valid_r  <= 1'b0;
                    done_r   <= 1'b0;
                    rd_ptr_r <= {RAM_AW{1'b0}};
                    count_r  <= 16'd0;
                end
            endcase
        end
    end

    assign o_data       = data_r;
    assign o_valid      = valid_r;
    assign o_burst_done = done_r;
    assign o_addr_err   = err_r;
    assign o_read_count = count_r;
    assign o_state      = state_r;

endmodule

// File: tb/tb_image_ram_responder.sv
// Directed self-checking bench for image_ram_responder with hand-computed expectations.
module tb_image_ram_responder;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_wr_en;
    logic [4:0]  i_wr_addr;
    logic [31:0] i_wr_data;
    logic        i_rst_ram;
    logic        i_en_ram;
    logic        i_addressing;
    logic [31:0] i_address;
    logic        i_read_term;
    logic [31:0] o_data;
    logic        o_valid;
    logic        o_burst_done;
    logic        o_addr_err;
    logic [15:0] o_read_count;
    logic [1:0]  o_state;

    int n_checks = 0;
    int n_fails  = 0;

    image_ram_responder dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr),
        .i_wr_data(i_wr_data), .i_rst_ram(i_rst_ram), .i_en_ram(i_en_ram),
        .i_addressing(i_addressing), .i_address(i_address), .i_read_term(i_read_term),
        .o_data(o_data), .o_valid(o_valid), .o_burst_done(o_burst_done),
        .o_addr_err(o_addr_err), .o_read_count(o_read_count), .o_state(o_state)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_reset = 1'b0; i_wr_en = 1'b0; i_wr_addr = 5'd0; i_wr_data = 32'd0;
        i_rst_ram = 1'b0; i_en_ram = 1'b0; i_addressing = 1'b0;
        i_address = 32'd0; i_read_term = 1'b0;
    endtask

    task automatic addr_read(input logic [31:0] a);
        i_en_ram = 1'b1; i_addressing = 1'b1; i_address = a;
    endtask

    task automatic seq_read();
        i_en_ram = 1'b1; i_addressing = 1'b0; i_address = 32'd0;
    endtask

    initial begin
        idle_inputs();
        i_reset = 1'b1;
        tick(); tick();
        check_value("rst_valid", {31'd0, o_valid}, 32'd0);
        check_value("rst_data", o_data, 32'd0);
        check_value("rst_state", {30'd0, o_state}, 32'd0);
        check_value("rst_count", {16'd0, o_read_count}, 32'd0);
        check_value("rst_err", {31'd0, o_addr_err}, 32'd0);
        check_value("rst_done", {31'd0, o_burst_done}, 32'd0);
        i_reset = 1'b0;

        // Preload mem[i] = i*3
        for (int i = 0; i < 32; i++) begin
            i_wr_en = 1'b1; i_wr_addr = 5'(i); i_wr_data = 32'(i * 3);
            tick();
            check_value("wr_no_valid", {31'd0, o_valid}, 32'd0);
        end
        i_wr_en = 1'b0;
        check_value("wr_state_idle", {30'd0, o_state}, 32'd0);

        // Test 1: four sequential reads
        for (int k = 0; k < 4; k++) begin
            seq_read();
            tick();
            check_value("t1_data", o_data, 32'(k * 3));
            check_value("t1_valid", {31'd0, o_valid}, 32'd1);
        end
        check_value("t1_count", {16'd0, o_read_count}, 32'd4);
        check_value("t1_state", {30'd0, o_state}, 32'd1);
        idle_inputs();
        tick();
        check_value("t1_gap_valid", {31'd0, o_valid}, 32'd0);
        check_value("t1_gap_data", o_data, 32'd0);

        // Close the burst without a request
        i_read_term = 1'b1;
        tick();
        check_value("term_done", {31'd0, o_burst_done}, 32'd1);
        check_value("term_state", {30'd0, o_state}, 32'd2);
        check_value("term_count_visible", {16'd0, o_read_count}, 32'd4);
        idle_inputs();
        tick();
        check_value("drain_exit_state", {30'd0, o_state}, 32'd0);
        check_value("drain_exit_done", {31'd0, o_burst_done}, 32'd0);
        check_value("drain_exit_count", {16'd0, o_read_count}, 32'd0);

        // Test 2: addressed reads including out of range
        addr_read(32'd5);  tick();
        check_value("t2_a5", o_data, 32'd15);
        check_value("t2_a5_err", {31'd0, o_addr_err}, 32'd0);
        addr_read(32'd31); tick();
        check_value("t2_a31", o_data, 32'd93);
        addr_read(32'd40); tick();
        check_value("t2_a40", o_data, 32'd0);
        check_value("t2_a40_valid", {31'd0, o_valid}, 32'd1);
        check_value("t2_a40_err", {31'd0, o_addr_err}, 32'd1);
        addr_read(32'h0000_0105); tick();
        check_value("t2_wide_addr", o_data, 32'd0);
        seq_read(); tick();
        check_value("t2_seq_mem0", o_data, 32'd0);
        check_value("t2_err_sticky", {31'd0, o_addr_err}, 32'd1);
        check_value("t2_count", {16'd0, o_read_count}, 32'd5);

        // i_rst_ram wins over simultaneous request and term
        idle_inputs();
        i_rst_ram = 1'b1; i_en_ram = 1'b1; i_read_term = 1'b1;
        tick();
        check_value("rr_valid", {31'd0, o_valid}, 32'd0);
        check_value("rr_done", {31'd0, o_burst_done}, 32'd0);
        check_value("rr_state", {30'd0, o_state}, 32'd0);
        check_value("rr_err", {31'd0, o_addr_err}, 32'd0);
        check_value("rr_count", {16'd0, o_read_count}, 32'd0);
        idle_inputs();

        // Test 3: 33 sequential reads wrap the pointer
        for (int k = 0; k < 33; k++) begin
            seq_read();
            tick();
            check_value("t3_data", o_data, 32'((k % 32) * 3));
        end
        check_value("t3_err", {31'd0, o_addr_err}, 32'd0);
        check_value("t3_count", {16'd0, o_read_count}, 32'd33);

        // Test 4: request with term, then dropped request in DRAIN
        seq_read(); i_read_term = 1'b1;
        tick();
        check_value("t4_last_data", o_data, 32'd3);
        check_value("t4_last_valid", {31'd0, o_valid}, 32'd1);
        check_value("t4_done", {31'd0, o_burst_done}, 32'd1);
        check_value("t4_count", {16'd0, o_read_count}, 32'd34);
        i_read_term = 1'b0;
        tick();
        check_value("t4_drop_valid", {31'd0, o_valid}, 32'd0);
        check_value("t4_done_pulse", {31'd0, o_burst_done}, 32'd0);
        check_value("t4_state_idle", {30'd0, o_state}, 32'd0);
        tick();
        check_value("t4_next_mem0", o_data, 32'd0);
        check_value("t4_next_valid", {31'd0, o_valid}, 32'd1);
        check_value("t4_next_count", {16'd0, o_read_count}, 32'd1);

        // Test 5: read-first on write/read collision
        addr_read(32'd7);
        i_wr_en = 1'b1; i_wr_addr = 5'd7; i_wr_data = 32'hDEADBEEF;
        tick();
        check_value("t5_old", o_data, 32'd21);
        i_wr_en = 1'b0;
        tick();
        check_value("t5_new", o_data, 32'hDEADBEEF);

        // Test 6: reset mid-stream retains memory
        for (int k = 0; k < 4; k++) begin
            seq_read();
            tick();
            check_value("t6_stream", o_data, 32'((k + 1) * 3));
        end
        i_reset = 1'b1;
        tick();
        check_value("t6_rst_valid", {31'd0, o_valid}, 32'd0);
        check_value("t6_rst_state", {30'd0, o_state}, 32'd0);
        check_value("t6_rst_count", {16'd0, o_read_count}, 32'd0);
        i_reset = 1'b0;
        addr_read(32'd7);
        tick();
        check_value("t6_mem7_kept", o_data, 32'hDEADBEEF);
        seq_read();
        tick();
        check_value("t6_mem0", o_data, 32'd0);
        check_value("t6_valid", {31'd0, o_valid}, 32'd1);
        idle_inputs();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
